gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Free-running WIDTH-bit Gray-code counter.
- Keeps an internal binary count and converts it to Gray code.
- Registers the Gray value so exactly one output bit toggles per clock.
- Used as a glitch-safe counter source, e.g. for pointers that cross clock domains or for low-toggle sequencing.

Parameters:
- WIDTH, default 4, counter and output width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- g  output  WIDTH  registered Gray-code count.

Interface:
- One clock; reset is asynchronous and active-high.
- Ports are named clk and rst.
- Port order is clk, rst, g, so positional instantiation works.

Behaviour:
- Reset:
  - While rst=1, the internal binary register b=0 and g=0 immediately, without waiting for a clock edge.
  - Holds regardless of clk.
- Counting, on each rising clk edge with rst=0:
  - b <= b + 1, modulo 2^WIDTH.
  - g <= bin2gray(b + 1), where bin2gray(x) = x XOR (x >> 1).
  - g therefore always equals bin2gray(b) and is driven directly from a flop, with no combinational path to the output.
- Latency:
  - First rising edge after rst falls: g = bin2gray(1) = 0...01.
  - No idle cycle after reset release.
- Sequence for WIDTH=4: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
- Wrap-around:
  - After b = 2^WIDTH - 1 (g = 10...0), the next edge gives b=0 and g=0.
  - Only the MSB changes on wrap; no terminal-count pulse.
- Invariant: Hamming distance between consecutive g values is exactly 1, including on wrap.
- Reset mid-count: asserting rst at any phase forces g=0 asynchronously. Counting restarts from 0 on the first edge after deassertion.
- Reset release coincident with a rising edge: that edge is not counted.
- No enable, no load, no direction control. The counter advances every cycle when out of reset.
- X-free: all flops are reset. No latches.

Decomposition:
- Package gray_pkg:
  - constant GRAY_DEFAULT_WIDTH = 4.
  - pure function bin2gray(x), parameterised by width.
  - pure function gray2bin(x): prefix XOR from the MSB down, used by benches and checkers.
- Sub-module bin_to_gray (parameter WIDTH; input bin[WIDTH-1:0], output gray[WIDTH-1:0]), purely combinational.
  - Instantiated on the b+1 next-state value, feeding the g register.
- Top gray_counter holds the binary register, the incrementer and the output register.
- Optional: a debug-only internal assertion that gray2bin(g) == b.

Test Plan:
1. Hold rst=1 for 10 ns with a 10 ns clock period (edge at 5 ns) -> g=0000 throughout; the edge during reset does not count.
2. Release rst at 10 ns -> edges at 15, 25, 35, 45 ns give g=0001, 0011, 0010, 0110.
3. Run 20 edges after release, ending at 205 ns -> g=0110 (b=4 after wrap). Every transition has Hamming distance 1.
4. Run 16 edges from reset -> g walks the full 16-entry sequence above and returns to 0000. The step 1000->0000 toggles only the MSB.
5. Assert rst asynchronously mid-cycle with g=1101 -> g=0000 before the next edge. After release, the first edge gives 0001.
6. WIDTH=8 -> after 255 edges g=10000000 and after 256 edges g=00000000. gray2bin(g) equals the edge count mod 256 at every cycle.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and Gray-code helpers for the gray_counter slice.
// Functions work on a 32-bit container; narrower callers zero-extend
// their operand and truncate the result back to their own width.
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;
    localparam int GRAY_MIN_WIDTH     = 2;
    localparam int GRAY_MAX_WIDTH     = 32;

    // Reflected binary code: each bit is the XOR of itself and its upper neighbour.
    // Zero upper bits in the container leave the narrow result unchanged.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Inverse mapping: running XOR from the MSB down to each bit position.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] x);
        logic [GRAY_MAX_WIDTH-1:0] r;
        r[GRAY_MAX_WIDTH-1] = x[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ x[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Purely combinational binary-to-Gray converter.
module bin_to_gray
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Widen into the package container, convert, and narrow back.
    always_comb begin
        gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin)));
    end

endmodule

// File: rtl/gray_counter.sv
// Free-running Gray-code counter. A binary register carries the count;
// the Gray output is registered from the converted next-state value so
// g is flop-driven and changes exactly one bit per clock.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] g
);

    // Reject widths the Gray helpers cannot represent.
    if (WIDTH < GRAY_MIN_WIDTH || WIDTH > GRAY_MAX_WIDTH) begin : g_width_check
        $error("gray_counter: WIDTH must lie in 2..32");
    end

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] g_nxt;

    // Incrementer wraps naturally modulo 2^WIDTH.
    always_comb begin
        b_nxt = b + WIDTH'(1);
    end

    bin_to_gray #(
        .WIDTH (WIDTH)
    ) u_bin_to_gray (
        .bin  (b_nxt),
        .gray (g_nxt)
    );

    // Binary count and Gray output advance together; reset clears both immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b <= '0;
            g <= '0;
        end else begin
            b <= b_nxt;
            g <= g_nxt;
        end
    end

`ifndef SYNTHESIS
    // Debug check that the output register never drifts from the binary count.
    always @(posedge clk) begin
        if (!rst) begin
            assert (gray2bin(GRAY_MAX_WIDTH'(g)) == GRAY_MAX_WIDTH'(b));
        end
    end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at WIDTH=4 and WIDTH=8 sharing one clock and reset.
module tb_gray_counter;
    import gray_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] g4;
    logic [7:0] g8;

    int n_checks;
    int n_errors;

    // Hand-written WIDTH=4 sequence, indexed by edge count mod 16.
    logic [3:0] seq4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_counter #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .g   (g4)
    );

    gray_counter #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .g   (g8)
    );

    // 10 ns period, first rising edge at 5 ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] prev4;
        logic [7:0] prev8;
        n_checks = 0;
        n_errors = 0;

        // Reset held from time 0; the edge at 5 ns must not count.
        rst = 1'b1;
        #1;
        chk("rst_g4_t1", 32'(g4), 32'h0);
        chk("rst_g8_t1", 32'(g8), 32'h00);
        @(posedge clk); #1;
        chk("rst_g4_t6", 32'(g4), 32'h0);
        chk("rst_g8_t6", 32'(g8), 32'h00);
        #4;
        rst = 1'b0;  // released at 10 ns

        prev4 = g4;
        prev8 = g8;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk); #1;
            chk($sformatf("seq4_e%0d", k), 32'(g4), 32'(seq4[k % 16]));
            chk($sformatf("ham4_e%0d", k), 32'($countones(g4 ^ prev4)), 32'd1);
            chk($sformatf("ham8_e%0d", k), 32'($countones(g8 ^ prev8)), 32'd1);
            chk($sformatf("g2b8_e%0d", k), gray2bin(32'(g8)), 32'(k % 256));
            if (k == 16) chk("wrap4_msb_only", 32'(g4 ^ prev4), 32'h8);
            if (k == 20) chk("g4_at_205ns", 32'(g4), 32'h6);
            if (k == 3)   chk("g8_e3",   32'(g8), 32'h02);
            if (k == 128) chk("g8_e128", 32'(g8), 32'hC0);
            if (k == 255) chk("g8_e255", 32'(g8), 32'h80);
            if (k == 256) begin
                chk("g8_e256", 32'(g8), 32'h00);
                chk("wrap8_msb_only", 32'(g8 ^ prev8), 32'h80);
            end
            prev4 = g4;
            prev8 = g8;
        end

        // Advance 9 more edges so g4 sits at 1101.
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
        end
        #1;
        chk("g4_pre_midrst", 32'(g4), 32'hD);
        chk("g8_pre_midrst", 32'(g8), 32'h0D);

        // Asynchronous reset mid-cycle: outputs clear before the next edge.
        #2 rst = 1'b1;
        #1;
        chk("g4_midrst_async", 32'(g4), 32'h0);
        chk("g8_midrst_async", 32'(g8), 32'h00);
        @(posedge clk); #1;
        chk("g4_midrst_hold", 32'(g4), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("g4_after_release", 32'(g4), 32'h0);
        @(posedge clk); #1;
        chk("g4_restart_e1", 32'(g4), 32'h1);
        chk("g8_restart_e1", 32'(g8), 32'h01);
        @(posedge clk); #1;
        chk("g4_restart_e2", 32'(g4), 32'h3);
        chk("g8_restart_e2", 32'(g8), 32'h03);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
